// File: rtl/phase_clk_gen_if.sv
// Control and gate-drive bundle for the two-phase clock generator.
// master drives the run/step controls; slave is the generator itself.
interface phase_clk_gen_if #(
  parameter int CNT_W = 16
);
  logic             run;
  logic             step_req;
  logic             phi1;
  logic             phi2;
  logic             sample;
  logic             sample_phase;
  logic [CNT_W-1:0] half_cnt;
  logic             busy;

  modport master (
    output run, step_req,
    input  phi1, phi2, sample, sample_phase, half_cnt, busy
  );

  modport slave (
    input  run, step_req,
    output phi1, phi2, sample, sample_phase, half_cnt, busy
  );
endinterface

// File: rtl/phase_clk_gen.sv
// Two-phase non-overlapping clock generator for the switch-level 6502 netlist.
// Each half-cycle holds one phase high for PHASE_CYCLES clocks, then both low
// for GAP_CYCLES clocks; a one-cycle sample strobe marks the last gap cycle.
module phase_clk_gen #(
  parameter int PHASE_CYCLES = 8,
  parameter int GAP_CYCLES   = 2,
  parameter int CNT_W        = 16
) (
  input  logic           clk,
  input  logic           rst,
  phase_clk_gen_if.slave bus
);

  // Timer only ever holds (cycles remaining - 1) of the longer state.
  localparam int MAX_HOLD = (PHASE_CYCLES > GAP_CYCLES) ? PHASE_CYCLES : GAP_CYCLES;
  localparam int TW       = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  localparam logic [TW-1:0] PHASE_LOAD = TW'(PHASE_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PHASE, GAP} state_t;
  typedef enum logic {PH1 = 1'b0, PH2 = 1'b1} phase_t;

  state_t           state;
  phase_t           next_phase;
  logic [TW-1:0]    cnt;
  logic             phi1;
  logic             phi2;
  logic             sample;
  logic             sample_phase;
  logic [CNT_W-1:0] half_cnt;
  logic             busy;
  logic             enter_last_gap;

  // Flags the edge that moves into the final gap cycle of a half-cycle.
  always_comb begin
    // NOTE: default first so every path assigns it; no latch is inferred.
    enter_last_gap = 1'b0;
    if (state == PHASE && cnt == '0 && GAP_CYCLES == 1)
      enter_last_gap = 1'b1;
    else if (state == GAP && cnt == TW'(1))
      enter_last_gap = 1'b1;
  end

  // Phase sequencer: state, timer, gate drives and strobe, all registered.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    if (rst) begin
      state        <= IDLE;
      next_phase   <= PH1;
      cnt          <= '0;
      phi1         <= 1'b0;
      phi2         <= 1'b0;
      sample       <= 1'b0;
      sample_phase <= 1'b0;
      half_cnt     <= '0;
      busy         <= 1'b0;
    end else begin
      if (enter_last_gap) begin
        sample       <= 1'b1;
        sample_phase <= next_phase;
        half_cnt     <= half_cnt + CNT_W'(1);
      end else begin
        sample <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (bus.run || bus.step_req) begin
            state <= PHASE;
            cnt   <= PHASE_LOAD;
            busy  <= 1'b1;
            phi1  <= (next_phase == PH1);
            phi2  <= (next_phase == PH2);
          end
        end

        PHASE: begin
          if (cnt == '0) begin
            state <= GAP;
            cnt   <= GAP_LOAD;
            phi1  <= 1'b0;
            phi2  <= 1'b0;
          end else begin
            cnt <= cnt - TW'(1);
          end
        end

        GAP: begin
          if (cnt == '0) begin
            // run is only looked at here, so a mid-half drop still finishes it.
            next_phase <= (next_phase == PH1) ? PH2 : PH1;
            if (bus.run) begin
              state <= PHASE;
              cnt   <= PHASE_LOAD;
              phi1  <= (next_phase == PH2);
              phi2  <= (next_phase == PH1);
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt - TW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.phi1         = phi1;
  assign bus.phi2         = phi2;
  assign bus.sample       = sample;
  assign bus.sample_phase = sample_phase;
  assign bus.half_cnt     = half_cnt;
  assign bus.busy         = busy;

endmodule

// File: tb/tb_phase_clk_gen.sv
// Directed bench for phase_clk_gen: default timing, 1/1 corner and a 4-bit
// half-cycle counter, each on its own instance sharing clk and rst.
module tb_phase_clk_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  phase_clk_gen_if #(.CNT_W(16)) if0 ();
  phase_clk_gen_if #(.CNT_W(16)) if1 ();
  phase_clk_gen_if #(.CNT_W(4))  if2 ();

  phase_clk_gen #(.PHASE_CYCLES(8), .GAP_CYCLES(2), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .bus(if0)
  );
  phase_clk_gen #(.PHASE_CYCLES(1), .GAP_CYCLES(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .bus(if1)
  );
  phase_clk_gen #(.PHASE_CYCLES(8), .GAP_CYCLES(2), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .bus(if2)
  );

  // Advance n cycles; inputs and outputs are touched 1 time unit after the edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves rst deasserted with all controls low; the current cycle is "cycle 0".
  task automatic do_reset();
    rst = 1'b1;
    if0.run = 1'b0; if0.step_req = 1'b0;
    if1.run = 1'b0; if1.step_req = 1'b0;
    if2.run = 1'b0; if2.step_req = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] got;
    do_reset();
    if0.run = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(1);
    got = {if0.phi1, if0.phi2, if0.sample, if0.sample_phase, if0.busy};
    checks++;
    if (got !== 5'b00000) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=00000", got);
    end
    checks++;
    if (if0.half_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_half_cnt got=%0d exp=0", if0.half_cnt);
    end
    if0.run = 1'b0;
  endtask

  task automatic test_free_run();
    logic [3:0]  got, exp;
    logic [15:0] exp_cnt;
    logic        prev_sample;
    int          h, p;
    do_reset();
    if0.run = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      tick(1);
      h = (c - 1) / 10;
      p = (c - 1) % 10;
      exp = {(p < 8) && (h % 2 == 0), (p < 8) && (h % 2 == 1), p == 9, 1'b1};
      got = {if0.phi1, if0.phi2, if0.sample, if0.busy};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL free_run_pins cycle=%0d got=%b exp=%b", c, got, exp);
      end
      exp_cnt = 16'(h + ((p == 9) ? 1 : 0));
      checks++;
      if (if0.half_cnt !== exp_cnt) begin
        errors++;
        $display("FAIL free_run_half_cnt cycle=%0d got=%0d exp=%0d", c, if0.half_cnt, exp_cnt);
      end
      if (p == 9) begin
        checks++;
        if (if0.sample_phase !== logic'(h % 2)) begin
          errors++;
          $display("FAIL free_run_sample_phase cycle=%0d got=%b exp=%0d", c, if0.sample_phase, h % 2);
        end
      end
    end
    prev_sample = if0.sample;
    for (int c = 0; c < 1000; c++) begin
      tick(1);
      checks++;
      if ((if0.phi1 && if0.phi2) || (if0.sample && prev_sample) ||
          (if0.sample && (if0.phi1 || if0.phi2))) begin
        errors++;
        $display("FAIL invariant cycle=%0d phi1=%b phi2=%b sample=%b prev_sample=%b",
                 c, if0.phi1, if0.phi2, if0.sample, prev_sample);
      end
      prev_sample = if0.sample;
    end
    if0.run = 1'b0;
  endtask

  task automatic test_step();
    int   n1, n2, ns;
    logic sp;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      if0.step_req = 1'b1;
      tick(1);
      if0.step_req = 1'b0;
      n1 = 0; n2 = 0; ns = 0; sp = 1'bx;
      for (int j = 1; j <= 19; j++) begin
        n1 += int'(if0.phi1);
        n2 += int'(if0.phi2);
        if (if0.sample) begin
          ns++;
          sp = if0.sample_phase;
        end
        tick(1);
      end
      checks++;
      if (n1 !== ((i % 2 == 0) ? 8 : 0) || n2 !== ((i % 2 == 1) ? 8 : 0) || ns !== 1) begin
        errors++;
        $display("FAIL step_%0d counts phi1=%0d phi2=%0d samples=%0d exp phi1=%0d phi2=%0d samples=1",
                 i, n1, n2, ns, (i % 2 == 0) ? 8 : 0, (i % 2 == 1) ? 8 : 0);
      end
      checks++;
      if (sp !== logic'(i % 2)) begin
        errors++;
        $display("FAIL step_%0d_sample_phase got=%b exp=%0d", i, sp, i % 2);
      end
      checks++;
      if (if0.busy !== 1'b0) begin
        errors++;
        $display("FAIL step_%0d_busy_between got=%b exp=0", i, if0.busy);
      end
    end
    checks++;
    if (if0.half_cnt !== 16'd3) begin
      errors++;
      $display("FAIL step_half_cnt got=%0d exp=3", if0.half_cnt);
    end
  endtask

  task automatic test_step_while_busy();
    int n1, n2;
    do_reset();
    if0.step_req = 1'b1;
    tick(1);
    if0.step_req = 1'b0;
    tick(3);
    if0.step_req = 1'b1;
    tick(1);
    if0.step_req = 1'b0;
    n1 = 0; n2 = 0;
    for (int c = 5; c < 30; c++) begin
      n1 += int'(if0.phi1);
      n2 += int'(if0.phi2);
      tick(1);
    end
    checks++;
    if (n1 !== 4 || n2 !== 0) begin
      errors++;
      $display("FAIL step_busy_phases phi1=%0d phi2=%0d exp phi1=4 phi2=0", n1, n2);
    end
    checks++;
    if (if0.half_cnt !== 16'd1 || if0.busy !== 1'b0) begin
      errors++;
      $display("FAIL step_busy_end half_cnt=%0d busy=%b exp half_cnt=1 busy=0", if0.half_cnt, if0.busy);
    end
  endtask

  task automatic test_run_drop();
    int n2;
    do_reset();
    if0.run = 1'b1;
    tick(11);
    n2 = 0;
    for (int c = 11; c <= 20; c++) begin
      if (c == 13) if0.run = 1'b0;
      n2 += int'(if0.phi2);
      if (c == 20) begin
        checks++;
        if (if0.sample !== 1'b1 || if0.sample_phase !== 1'b1) begin
          errors++;
          $display("FAIL run_drop_sample sample=%b phase=%b exp sample=1 phase=1",
                   if0.sample, if0.sample_phase);
        end
      end
      tick(1);
    end
    checks++;
    if (n2 !== 8) begin
      errors++;
      $display("FAIL run_drop_phi2_len got=%0d exp=8", n2);
    end
    tick(3);
    checks++;
    if ({if0.phi1, if0.phi2, if0.busy} !== 3'b000 || if0.half_cnt !== 16'd2) begin
      errors++;
      $display("FAIL run_drop_idle phi1/phi2/busy=%b half_cnt=%0d exp 000 half_cnt=2",
               {if0.phi1, if0.phi2, if0.busy}, if0.half_cnt);
    end
    if0.run = 1'b1;
    tick(1);
    checks++;
    if ({if0.phi1, if0.phi2} !== 2'b10) begin
      errors++;
      $display("FAIL run_drop_restart phi1/phi2=%b exp=10", {if0.phi1, if0.phi2});
    end
    if0.run = 1'b0;
  endtask

  task automatic test_reset_mid_phase();
    logic [3:0] got;
    do_reset();
    if0.run = 1'b1;
    tick(5);
    rst = 1'b1;
    tick(1);
    got = {if0.phi1, if0.phi2, if0.busy, if0.sample};
    checks++;
    if (got !== 4'b0000 || if0.half_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid_phase phi1/phi2/busy/sample=%b half_cnt=%0d exp 0000 half_cnt=0",
               got, if0.half_cnt);
    end
    rst = 1'b0;
    tick(1);
    got = {if0.phi1, if0.phi2, if0.busy, if0.sample};
    checks++;
    if (got !== 4'b1010) begin
      errors++;
      $display("FAIL reset_mid_restart phi1/phi2/busy/sample=%b exp=1010", got);
    end
    if0.run = 1'b0;
  endtask

  task automatic test_corner_1_1();
    logic [7:0] e_phi1, e_phi2, e_samp;
    logic [3:0] got, exp;
    do_reset();
    e_phi1 = 8'b0001_0001;
    e_phi2 = 8'b0100_0100;
    e_samp = 8'b1010_1010;
    if1.run = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick(1);
      exp = {e_phi1[c-1], e_phi2[c-1], e_samp[c-1], (c % 4 == 0)};
      got = {if1.phi1, if1.phi2, if1.sample, if1.sample && if1.sample_phase};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL corner_pins cycle=%0d phi1/phi2/sample/phase=%b exp=%b", c, got, exp);
      end
      checks++;
      if (if1.half_cnt !== 16'(c / 2)) begin
        errors++;
        $display("FAIL corner_half_cnt cycle=%0d got=%0d exp=%0d", c, if1.half_cnt, c / 2);
      end
    end
    if1.run = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    if2.run = 1'b1;
    tick(159);
    checks++;
    if (if2.half_cnt !== 4'd15) begin
      errors++;
      $display("FAIL wrap_pre got=%0d exp=15", if2.half_cnt);
    end
    tick(1);
    checks++;
    if (if2.half_cnt !== 4'd0 || if2.sample !== 1'b1) begin
      errors++;
      $display("FAIL wrap_zero half_cnt=%0d sample=%b exp half_cnt=0 sample=1", if2.half_cnt, if2.sample);
    end
    tick(5);
    if2.run = 1'b0;
    tick(6);
    checks++;
    if (if2.half_cnt !== 4'd1 || if2.busy !== 1'b0) begin
      errors++;
      $display("FAIL wrap_17 half_cnt=%0d busy=%b exp half_cnt=1 busy=0", if2.half_cnt, if2.busy);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_step();
    test_step_while_busy();
    test_run_drop();
    test_reset_mid_phase();
    test_corner_1_1();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
